// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- UART receive sequencer.
//
// Drives an external edge/bit counter through Cnt_Enable. The counter provides
// Edge_count and Bit_count. The block takes a 2-of-3 majority vote around
// mid-bit and shifts data in LSB-first. It checks the parity and stop bits and
// publishes each error-free word on P_DATA with a one-cycle Data_Valid strobe.
//
// Build option: define UART_RX_START_GLITCH_EN to abandon a frame whose start
// bit votes high (a line glitch). Without it, START always proceeds to DATA.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, counter held clear, waiting for RX_IN low
// START  | timing the start bit (Bit_count = 0)
// DATA   | shifting in data bits, Bit_count = 1..DATA_WIDTH
// PARITY | comparing the parity bit with the parity of the received word
// STOP   | checking the stop bit, publishing the word when the frame is clean

module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [4:0]            Edge_count,
   input  logic [4:0]            Bit_count,
   output logic                  Cnt_Enable,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Par_Err,
   output logic                  Stp_Err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [4:0] LAST_DATA_BIT = 5'(DATA_WIDTH);

   state_t                state_q;
   state_t                state_nx;
   logic [2:0]            smp_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_en_q;
   logic                  par_typ_q;

   logic [5:0]            edge_ext;
   logic [5:0]            ps_last;
   logic [5:0]            ps_mid;
   logic                  bit_end;
   logic                  smp_bit;
   logic                  par_exp;
   logic                  frame_go;

   assign edge_ext = {1'b0, Edge_count};
   assign ps_last  = Prescale - 6'd1;
   assign ps_mid   = {1'b0, Prescale[5:1]};

   // A 5-bit counter always passes 31. Treating 31 as a bit end keeps the
   // sequencer moving if an unsupported Prescale makes Prescale-1 unreachable.
   // For Prescale 8 and 16 the counter never gets there, and for 32 it is the
   // real bit end anyway.
   assign bit_end  = (edge_ext == ps_last) || (Edge_count == 5'h1f);
   assign smp_bit  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
   assign par_exp  = par_typ_q ? ~(^shift_q) : (^shift_q);
   assign frame_go = (state_q == IDLE) && !RX_IN;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE: begin
            if (!RX_IN) begin
               state_nx = START;
            end
         end
         START: begin
            if (bit_end && (Bit_count == 5'd0)) begin
`ifdef UART_RX_START_GLITCH_EN
               state_nx = smp_bit ? IDLE : DATA;
`else
               state_nx = DATA;
`endif
            end
         end
         DATA: begin
            if (bit_end && (Bit_count == LAST_DATA_BIT)) begin
               state_nx = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nx = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output decode: the counter runs whenever a frame is in progress
   always_comb begin
      Cnt_Enable = (state_q != IDLE);
   end

   // Mid-bit samples: three consecutive edges centred on Prescale/2-1
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         smp_q <= 3'b000;
      end else if (state_q != IDLE) begin
         if (edge_ext == ps_mid - 6'd2) smp_q[0] <= RX_IN;
         if (edge_ext == ps_mid - 6'd1) smp_q[1] <= RX_IN;
         if (edge_ext == ps_mid)        smp_q[2] <= RX_IN;
      end
   end

   // Frame configuration is frozen at the start bit so mid-frame changes wait for the next frame
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else if (frame_go) begin
         par_en_q  <= PAR_EN;
         par_typ_q <= PAR_TYP;
      end
   end

   // Data shift register: the new bit enters at the MSB, so the first bit ends up in the LSB
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_q <= '0;
      end else if ((state_q == DATA) && bit_end) begin
         shift_q <= {smp_bit, shift_q[DATA_WIDTH-1:1]};
      end
   end

   // Error flags, held until the next start bit
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Par_Err <= 1'b0;
         Stp_Err <= 1'b0;
      end else if (frame_go) begin
         Par_Err <= 1'b0;
         Stp_Err <= 1'b0;
      end else if (bit_end) begin
         if ((state_q == PARITY) && (smp_bit != par_exp)) begin
            Par_Err <= 1'b1;
         end
         if ((state_q == STOP) && !smp_bit) begin
            Stp_Err <= 1'b1;
         end
      end
   end

   // Publish a clean word at the end of the stop bit with a single-cycle strobe
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         P_DATA     <= '0;
         Data_Valid <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         if ((state_q == STOP) && bit_end && smp_bit && !Par_Err) begin
            P_DATA     <= shift_q;
            Data_Valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl. It provides the edge/bit counter that the receiver
// enables and drives serial frames. A frame-level model predicts the outputs
// on every cycle: when each frame starts, when its parity and stop bits are
// judged, and when the word is published.
module tb_uart_rx_ctrl;
   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          RX_IN;
   logic [5:0]    Prescale;
   logic          PAR_EN;
   logic          PAR_TYP;
   logic [4:0]    Edge_count;
   logic [4:0]    Bit_count;
   logic          Cnt_Enable;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          Par_Err;
   logic          Stp_Err;

   uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .Prescale   (Prescale),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Edge_count (Edge_count),
      .Bit_count  (Bit_count),
      .Cnt_Enable (Cnt_Enable),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .Par_Err    (Par_Err),
      .Stp_Err    (Stp_Err)
   );

   always #5 CLK = ~CLK;

   // Edge/bit counter that the receiver relies on
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         Edge_count <= 5'd0;
         Bit_count  <= 5'd0;
      end else if (!Cnt_Enable) begin
         Edge_count <= 5'd0;
         Bit_count  <= 5'd0;
      end else if (Edge_count == 5'(Prescale - 6'd1)) begin
         Edge_count <= 5'd0;
         Bit_count  <= Bit_count + 5'd1;
      end else begin
         Edge_count <= Edge_count + 5'd1;
      end
   end

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One predicted frame: t0 is the cycle the start bit is detected, par_end
   // the cycle the parity bit is judged, e the cycle the frame finishes.
   typedef struct {
      int unsigned   t0;
      int unsigned   par_end;
      int unsigned   e;
      logic [DW-1:0] data;
      bit            par_bad;
      bit            stp_bad;
      bit            no_dv;
   } frame_t;

   frame_t        q[$];
   frame_t        cur;
   bit            have_cur = 1'b0;
   bit            exp_dv   = 1'b0;
   bit            exp_par  = 1'b0;
   bit            exp_stp  = 1'b0;
   logic [DW-1:0] exp_pdata = '0;
   int            dv_seen  = 0;
   int            dv_exp   = 0;
   logic [DW-1:0] dv_log[$];
   int unsigned   last_end = 0;

   // Model update and per-cycle comparison
   always @(negedge CLK) begin
      if (RST) begin
         have_cur  = 1'b0;
         exp_dv    = 1'b0;
         exp_par   = 1'b0;
         exp_stp   = 1'b0;
         exp_pdata = '0;
      end else begin
         exp_dv = 1'b0;
         if (!have_cur && (q.size() > 0) && (q[0].t0 == cyc)) begin
            cur      = q.pop_front();
            have_cur = 1'b1;
            exp_par  = 1'b0;
            exp_stp  = 1'b0;
         end
         if (have_cur) begin
            if (cur.par_bad && (cyc == cur.par_end)) exp_par = 1'b1;
            if (cyc == cur.e) begin
               if (cur.stp_bad) begin
                  exp_stp = 1'b1;
               end else if (!cur.no_dv && !exp_par) begin
                  exp_dv    = 1'b1;
                  exp_pdata = cur.data;
               end
               have_cur = 1'b0;
            end
         end
      end
      if (Data_Valid) begin
         dv_seen++;
         dv_log.push_back(P_DATA);
      end
      if (exp_dv) dv_exp++;
      check("Cnt_Enable", 32'(Cnt_Enable), 32'(have_cur));
      check("Data_Valid", 32'(Data_Valid), 32'(exp_dv));
      check("P_DATA",     32'(P_DATA),     32'(exp_pdata));
      check("Par_Err",    32'(Par_Err),    32'(exp_par));
      check("Stp_Err",    32'(Stp_Err),    32'(exp_stp));
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_Cnt_Enable"}, 32'(Cnt_Enable), 32'd0);
      check({tag, "_P_DATA"},     32'(P_DATA),     32'd0);
      check({tag, "_Data_Valid"}, 32'(Data_Valid), 32'd0);
      check({tag, "_Par_Err"},    32'(Par_Err),    32'd0);
      check({tag, "_Stp_Err"},    32'(Stp_Err),    32'd0);
   endtask

   // Drive one frame on the line and record its predicted outcome
   task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen, input bit ptyp,
                             input bit pbad, input bit sbad, input int pre, input bit glitch,
                             input bit flip, input bit rst_mid);
      frame_t      f;
      int unsigned s;
      logic        pbit;
      wait_cyc(pre);
      Prescale = 6'(p);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      RX_IN    = 1'b0;
      s        = cyc;
      f.t0      = (s + 1 > last_end + 1) ? s + 1 : last_end + 1;
      f.par_end = f.t0 + (DW + 2) * p;
      f.e       = f.t0 + (DW + 2 + (pen ? 1 : 0)) * p;
      f.data    = d;
      f.par_bad = pen && pbad;
      f.stp_bad = sbad;
      f.no_dv   = 1'b0;
`ifdef UART_RX_START_GLITCH_EN
      if (glitch) begin
         f.e       = f.t0 + p;
         f.no_dv   = 1'b1;
         f.stp_bad = 1'b0;
         f.par_bad = 1'b0;
      end
`endif
      q.push_back(f);
      last_end = f.e;
      if (glitch) begin
         wait_cyc(2);
         RX_IN = 1'b1;
         wait_cyc(p - 2);
      end else begin
         wait_cyc(p);
      end
      for (int i = 0; i < DW; i++) begin
         RX_IN = d[i];
         if (rst_mid && (i == 3)) begin
            wait_cyc(p / 2);
            check("pre_rst_busy", 32'(Cnt_Enable), 32'd1);
            RST = 1'b1;
            q.delete();
            last_end = 0;
            RX_IN = 1'b1;
            #1;
            check_all_zero("rst_async");
            wait_cyc(3);
            RST = 1'b0;
            return;
         end
         if (flip && (i == 2)) begin
            PAR_EN  = 1'($urandom_range(0, 1));
            PAR_TYP = 1'($urandom_range(0, 1));
         end
         wait_cyc(p);
      end
      if (pen) begin
         pbit  = (ptyp ? ~(^d) : (^d)) ^ pbad;
         RX_IN = pbit;
         wait_cyc(p);
      end
      RX_IN = ~sbad;
      wait_cyc(p);
      RX_IN = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dv0;
      RST      = 1'b1;
      RX_IN    = 1'b1;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      wait_cyc(3);
      check_all_zero("reset");
      RST = 1'b0;
      wait_cyc(2);

      // 0xA5, Prescale 8, no parity
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      wait_cyc(3);
      check("a5_pdata", 32'(P_DATA), 32'hA5);
      check("a5_dv_count", 32'(dv_seen), 32'd1);
      check("a5_par", 32'(Par_Err), 32'd0);
      check("a5_stp", 32'(Stp_Err), 32'd0);

      // 0x3C, Prescale 16, even parity, wrong parity bit (1)
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      wait_cyc(3);
      check("3c_par", 32'(Par_Err), 32'd1);
      check("3c_pdata", 32'(P_DATA), 32'hA5);
      check("3c_dv_count", 32'(dv_seen), 32'd1);

      // 0x55, Prescale 8, stop bit low
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
      wait_cyc(3);
      check("55_stp", 32'(Stp_Err), 32'd1);
      check("55_par_cleared", 32'(Par_Err), 32'd0);
      check("55_pdata", 32'(P_DATA), 32'hA5);

      // next clean frame clears the stop error
      send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      wait_cyc(3);
      check("12_stp_cleared", 32'(Stp_Err), 32'd0);
      check("12_pdata", 32'(P_DATA), 32'h12);

      // start glitch: line low for two edges only
      dv0 = dv_seen;
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
      wait_cyc(3);
`ifdef UART_RX_START_GLITCH_EN
      check("glitch_pdata", 32'(P_DATA), 32'h12);
      check("glitch_dv_count", 32'(dv_seen - dv0), 32'd0);
`else
      check("glitch_pdata", 32'(P_DATA), 32'hFF);
      check("glitch_dv_count", 32'(dv_seen - dv0), 32'd1);
`endif
      check("glitch_par", 32'(Par_Err), 32'd0);
      check("glitch_stp", 32'(Stp_Err), 32'd0);

      // back-to-back 0x00 then 0xFF, Prescale 32, odd parity
      dv0 = dv_seen;
      send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      wait_cyc(4);
      check("pair_dv_count", 32'(dv_seen - dv0), 32'd2);
      if (dv_log.size() >= 2) begin
         check("pair_first", 32'(dv_log[dv_log.size() - 2]), 32'h00);
         check("pair_second", 32'(dv_log[dv_log.size() - 1]), 32'hFF);
      end else begin
         check("pair_log_size", 32'(dv_log.size()), 32'd2);
      end

      // reset in the middle of data bit 4, then a full 0x81 frame
      dv0 = dv_seen;
      send_frame(8'h6B, 8, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
      wait_cyc(3);
      check("81_pdata", 32'(P_DATA), 32'h81);
      check("81_dv_count", 32'(dv_seen - dv0), 32'd1);

      // randomized frames
      for (int n = 0; n < 40; n++) begin
         logic [DW-1:0] d;
         int            p;
         bit            pen, ptyp, pbad, sbad, gl, fl;
         d    = DW'($urandom);
         p    = 8 << $urandom_range(0, 2);
         pen  = 1'($urandom_range(0, 1));
         ptyp = 1'($urandom_range(0, 1));
         pbad = ($urandom_range(0, 3) == 0);
         sbad = ($urandom_range(0, 4) == 0);
         gl   = ($urandom_range(0, 9) == 0);
         fl   = ($urandom_range(0, 2) == 0);
         if (gl) begin
            d    = '1;
            pen  = 1'b0;
            sbad = 1'b0;
         end
         send_frame(d, p, pen, ptyp, pbad, sbad, int'($urandom_range(2, 6)), gl, fl, 1'b0);
      end
      wait_cyc(5);
      check("dv_total", 32'(dv_seen), 32'(dv_exp));
      check("model_drained", 32'(q.size()), 32'd0);
      check("model_idle", 32'(have_cur), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
